// File: rtl/slug_pkg.sv
// Shared definitions for the slug execution core: widths, 74181 function codes, flags layout.
package slug_pkg;

  localparam int PC_W = 16;
  localparam int DW   = 4;

  localparam logic [3:0] ALU_NOT_A  = 4'b0000;
  localparam logic [3:0] ALU_MINUS1 = 4'b0011;
  localparam logic [3:0] ALU_SUB    = 4'b0110;
  localparam logic [3:0] ALU_ADD    = 4'b1001;
  localparam logic [3:0] ALU_B      = 4'b1010;
  localparam logic [3:0] ALU_AND    = 4'b1011;
  localparam logic [3:0] ALU_DEC_A  = 4'b1111;

  typedef struct packed {
    logic zero;
    logic carry;
  } flags_t;

endpackage

// File: rtl/slug_alu181.sv
// Combinational 74181-style ALU: function select S, mode M, active-high carry in.
module slug_alu181
  import slug_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [3:0]    s,
  input  logic          m,
  input  logic          crin,
  output logic [DW-1:0] f,
  output logic          carry,
  output logic          zero
);

  logic [DW-1:0] x;
  logic [DW-1:0] y;
  logic [DW:0]   sum;

  // Generate/propagate terms of the 74181; arithmetic is just their sum.
  assign x   = a | (b & {DW{s[0]}}) | (~b & {DW{s[1]}});
  assign y   = (a & ~b & {DW{s[2]}}) | (a & b & {DW{s[3]}});
  assign sum = {1'b0, x} + {1'b0, y} + {{DW{1'b0}}, crin};

  always_comb begin
    f     = '0;
    carry = 1'b0;
    if (m) begin
      f = ~(x ^ y);
    end else begin
      f     = sum[DW-1:0];
      carry = sum[DW];
    end
  end

  assign zero = (f == '0);

endmodule

// File: rtl/slug_exec_core.sv
// slug CPU execution core: PC, ALU-fed accumulator and flags, 3-to-8 select decoder.
// Build option SLUG_ROTB_EN enables the rotated-accumulator B operand source.
module slug_exec_core #(
  parameter int PC_W = slug_pkg::PC_W,
  parameter int DW   = slug_pkg::DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_ld,
  input  logic            pc_inc,
  input  logic [PC_W-1:0] pc_d,
  output logic [PC_W-1:0] pc_q,
  input  logic [3:0]      alu_s,
  input  logic            alu_m,
  input  logic            alu_crin,
  input  logic            b_sel_data,
  input  logic [DW-1:0]   data_in,
  input  logic            a_ld,
  input  logic            fl_ld,
  output logic [DW-1:0]   alu_f,
  output logic [DW-1:0]   a_q,
  output logic [1:0]      flags_q,
  input  logic [2:0]      sel,
  output logic [7:0]      dsel
);

  import slug_pkg::*;

  logic [DW-1:0] alu_b;
  logic          alu_carry;
  logic          alu_zero;
  flags_t        flags_r;

`ifdef SLUG_ROTB_EN
  // Rotate reads the registered accumulator, so there is no loop through the ALU.
  assign alu_b = b_sel_data ? data_in : {a_q[0], a_q[DW-1:1]};
`else
  logic unused_b_sel;
  assign unused_b_sel = b_sel_data;
  assign alu_b        = data_in;
`endif

  slug_alu181 u_alu (
    .a     (a_q),
    .b     (alu_b),
    .s     (alu_s),
    .m     (alu_m),
    .crin  (alu_crin),
    .f     (alu_f),
    .carry (alu_carry),
    .zero  (alu_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= '0;
    end else if (pc_ld) begin
      pc_q <= pc_d;
    end else if (pc_inc) begin
      pc_q <= pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q     <= '0;
      flags_r <= '0;
    end else begin
      if (a_ld)  a_q     <= alu_f;
      if (fl_ld) flags_r <= '{zero: alu_zero, carry: alu_carry};
    end
  end

  assign flags_q = flags_r;
  assign dsel    = 8'b0000_0001 << sel;

endmodule

// File: tb/tb_slug_exec_core.sv
// Directed self-checking bench for slug_exec_core with hand-computed expectations.
module tb_slug_exec_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_ld = 1'b0, pc_inc = 1'b0;
  logic [15:0] pc_d = '0;
  logic [15:0] pc_q;
  logic [3:0]  alu_s = '0;
  logic        alu_m = 1'b0, alu_crin = 1'b0, b_sel_data = 1'b1;
  logic [3:0]  data_in = '0;
  logic        a_ld = 1'b0, fl_ld = 1'b0;
  logic [3:0]  alu_f, a_q;
  logic [1:0]  flags_q;
  logic [2:0]  sel = '0;
  logic [7:0]  dsel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  slug_exec_core dut (
    .clk(clk), .rst(rst), .pc_ld(pc_ld), .pc_inc(pc_inc), .pc_d(pc_d), .pc_q(pc_q),
    .alu_s(alu_s), .alu_m(alu_m), .alu_crin(alu_crin), .b_sel_data(b_sel_data),
    .data_in(data_in), .a_ld(a_ld), .fl_ld(fl_ld), .alu_f(alu_f), .a_q(a_q),
    .flags_q(flags_q), .sel(sel), .dsel(dsel)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Load the accumulator through the logic-mode pass-B function.
  task automatic load_a(input logic [3:0] v);
    alu_s = 4'b1010; alu_m = 1'b1; b_sel_data = 1'b1; data_in = v; a_ld = 1'b1;
    tick();
    a_ld = 1'b0;
  endtask

  initial begin
    #12 rst = 1'b1;
    tick();

    // Build up nonzero state, then reset between edges.
    pc_ld = 1'b1; pc_d = 16'h0055; tick(); pc_ld = 1'b0;
    load_a(4'h6);
    alu_s = 4'b1001; alu_m = 1'b0; data_in = 4'h3; fl_ld = 1'b1; tick(); fl_ld = 1'b0;
    chk("pre_rst_a", a_q, 4'h6);
    #2 rst = 1'b0;
    #1;
    chk("rst_pc", pc_q, 16'h0000);
    chk("rst_a", a_q, 4'h0);
    chk("rst_flags", flags_q, 2'b00);
    tick();
    #3 rst = 1'b1;
    tick();

    pc_ld = 1'b1; pc_d = 16'h1234; tick(); pc_ld = 1'b0;
    pc_inc = 1'b1; tick(); tick(); pc_inc = 1'b0;
    chk("pc_inc2", pc_q, 16'h1236);
    tick();
    chk("pc_hold", pc_q, 16'h1236);

    pc_ld = 1'b1; pc_d = 16'hFFFF; tick(); pc_ld = 1'b0;
    pc_inc = 1'b1; tick(); pc_inc = 1'b0;
    chk("pc_wrap", pc_q, 16'h0000);
    pc_ld = 1'b1; pc_inc = 1'b1; pc_d = 16'hABCD; tick();
    pc_ld = 1'b0; pc_inc = 1'b0;
    chk("pc_ld_prio", pc_q, 16'hABCD);

    // 9 + 7 = 16: result 0 with carry out.
    load_a(4'h9);
    chk("a_load9", a_q, 4'h9);
    alu_s = 4'b1001; alu_m = 1'b0; alu_crin = 1'b0; data_in = 4'h7;
    #1 chk("add_f", alu_f, 4'h0);
    a_ld = 1'b1; fl_ld = 1'b1; tick(); a_ld = 1'b0; fl_ld = 1'b0;
    chk("add_a", a_q, 4'h0);
    chk("add_flags", flags_q, 2'b11);

    // 5 - 3 and 5 - 6 with crin=1.
    load_a(4'h5);
    alu_s = 4'b0110; alu_m = 1'b0; alu_crin = 1'b1; data_in = 4'h3;
    #1 chk("sub_f", alu_f, 4'h2);
    fl_ld = 1'b1; tick(); fl_ld = 1'b0;
    chk("sub_flags", flags_q, 2'b01);
    data_in = 4'h6;
    #1 chk("sub_neg_f", alu_f, 4'hF);
    fl_ld = 1'b1; tick(); fl_ld = 1'b0;
    chk("sub_neg_flags", flags_q, 2'b00);
    chk("sub_a_held", a_q, 4'h5);

    // Other table entries with A = 5.
    alu_crin = 1'b0; alu_m = 1'b0; alu_s = 4'b0011;
    #1 chk("minus1", alu_f, 4'hF);
    alu_s = 4'b1111;
    #1 chk("dec_a", alu_f, 4'h4);
    alu_m = 1'b1; alu_s = 4'b0000;
    #1 chk("not_a", alu_f, 4'hA);
    alu_s = 4'b1011; data_in = 4'hC;
    #1 chk("and_ab", alu_f, 4'h4);
    fl_ld = 1'b1; tick(); fl_ld = 1'b0;
    chk("logic_flags", flags_q, 2'b00);

    // Logic mode zero result sets zero, never carry.
    data_in = 4'h2;
    fl_ld = 1'b1; tick(); fl_ld = 1'b0;
    chk("logic_zero", flags_q, 2'b10);

    // B source selection.
    load_a(4'h1);
    alu_s = 4'b1010; alu_m = 1'b1; b_sel_data = 1'b0; data_in = 4'h3;
`ifdef SLUG_ROTB_EN
    #1 chk("rot_b", alu_f, 4'h8);
`else
    #1 chk("rot_b_off", alu_f, 4'h3);
`endif
    b_sel_data = 1'b1;

    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      #1 chk($sformatf("dsel_%0d", i), dsel, 32'h1 << i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/slug_exec_core.md
# slug_exec_core

Execution core of the 4-bit slug CPU: a 16-bit program counter with load/increment, a 74181-style 4-bit ALU feeding an accumulator and a 2-bit flag register, and a 3-to-8 one-hot select decoder. It sits between the microcode control word and the data/address buses. All control inputs are active-high; inversion of ROM bits is done upstream.

## Interface
- `PC_W`, default 16: program counter width.
- `DW`, default 4: ALU, accumulator and data width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `pc_ld`  in  1  load the PC from `pc_d`.
- `pc_inc`  in  1  increment the PC.
- `pc_d`  in  PC_W  PC load value (address bus).
- `pc_q`  out  PC_W  current PC.
- `alu_s`  in  4  74181 function select.
- `alu_m`  in  1  1 = logic mode, 0 = arithmetic mode.
- `alu_crin`  in  1  carry in, active-high (1 adds one).
- `b_sel_data`  in  1  B operand source: 1 = `data_in`, 0 = rotated accumulator.
- `data_in`  in  DW  data bus.
- `a_ld`  in  1  load the accumulator from `alu_f`.
- `fl_ld`  in  1  load the flags from {zero, carry}.
- `alu_f`  out  DW  combinational ALU result.
- `a_q`  out  DW  accumulator.
- `flags_q`  out  2  registered flags: [1] = zero, [0] = carry.
- `sel`  in  3  decoder input.
- `dsel`  out  8  one-hot decode of `sel`.

## Operation
- **PC:** `pc_ld` has priority over `pc_inc`. On `pc_inc` alone the PC increments modulo 2^PC_W. With neither asserted the PC holds.
- **ALU operands:**
  - A = `a_q`.
  - B = `data_in` when `b_sel_data` = 1.
  - Otherwise B = {a_q[0], a_q[3], a_q[2], a_q[1]}, i.e. rotate-right by one (see Configuration).
- **ALU internals:**
  - X = A | (B & {4{S0}}) | (~B & {4{S1}}).
  - Y = (A & ~B & {4{S2}}) | (A & B & {4{S3}}).
- **Arithmetic mode (M = 0):** {carry, F} = X + Y + crin, computed at 5 bits. This reproduces the 74181 table; examples: S=1001 gives A plus B, S=0110 gives A minus B minus 1, S=0011 gives minus 1, S=1111 gives A minus 1.
- **Logic mode (M = 1):** F = ~(X ^ Y) and carry = 0. Examples: S=1010 gives B, S=1011 gives A & B, S=0000 gives ~A.
- **Zero flag:** zero = (F == 0), in both modes.
- **Registers:**
  - `a_ld` captures F into the accumulator.
  - `fl_ld` captures {zero, carry}.
  - The two loads are independent.
- **Decoder:** dsel = 1 << sel, purely combinational, with exactly one bit set at all times.

## Timing
- Reset (asynchronous assert while `rst` = 0): `pc_q` = 0, `a_q` = 0, `flags_q` = 0. Release is synchronised by the caller. Reset asserted mid-operation overrides any pending load or increment immediately.
- `alu_f`, `dsel` and the zero/carry nets are combinational, zero latency.
- `pc_q`, `a_q` and `flags_q` change one cycle after their control is sampled.
- When `a_ld` and `fl_ld` are asserted together, both capture values computed from the pre-edge `a_q`.
- Rotate feedback has no combinational loop: it reads the registered `a_q`.

## Configuration
- `SLUG_ROTB_EN`: the rotated-accumulator B source.
  - Defined: B = rotate-right of `a_q` when `b_sel_data` = 0.
  - Undefined: B = `data_in` regardless of `b_sel_data`; the port stays present but is ignored.

## Structure
- Shared package `slug_pkg`: width constants (`PC_W`, `DW`), the `alu_s` encoding constants (for example `ALU_ADD` = 4'b1001, `ALU_SUB` = 4'b0110, `ALU_B` = 4'b1010), and a flags struct {zero, carry}.
- One sub-module, `slug_alu181`: the combinational ALU (A, B, S, M, crin → F, carry, zero). PC, registers and decoder stay inline.

## Test plan
- **Reset and PC:** assert `rst` = 0 mid-run → `pc_q` = 0, `a_q` = 0, `flags_q` = 0 without waiting for a clock edge. Then load 0x1234 and apply two `pc_inc` cycles → `pc_q` = 0x1236.
- **PC wrap and priority:** PC = 0xFFFF, `pc_inc` → 0x0000. `pc_ld` with `pc_d` = 0xABCD plus `pc_inc` in the same cycle → 0xABCD.
- **Add with carry-out:**
  - Load A = 9 via S=1010, M=1, `data_in` = 9, `a_ld`.
  - Then S=1001, M=0, crin=0, `data_in` = 7, `a_ld` + `fl_ld`.
  - Expect `a_q` = 0x0 and `flags_q` = 2'b11.
- **Subtract:** A = 5, S=0110, M=0, crin=1, `data_in` = 3 → F = 2, carry = 1, zero = 0. With `data_in` = 6 → F = 0xF, carry = 0.
- **Rotate path (SLUG_ROTB_EN defined):** A = 0x1, `b_sel_data` = 0, S=1010, M=1 → F = 0x8. With the macro undefined and `data_in` = 0x3 → F = 0x3.
- **Decoder:** sweep `sel` 0..7 → `dsel` = 0x01, 0x02, 0x04, 0x08, 0x10, 0x20, 0x40, 0x80 (for example, `sel` = 5 → 0x20).
